xor_result_checker: RTL and testbench

//  Hardware response checker/scoreboard for the registered XOR datapath: consumes the operands driven into it plus its result.

---
 rtl/xor_chk_pkg.sv | 33 +++
 rtl/xor_chk_delay_line.sv | 59 +++++
 rtl/xor_result_checker.sv | 145 ++++++++++++++
 tb/tb_xor_result_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor_chk_pkg.sv
// Shared types and helpers for the XOR result checker: FSM state encoding,
// coverage bin count, operand-to-bin mapping and bitmap popcount.
package xor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } chk_state_e;

  localparam int NUM_BINS  = 8;
  localparam int BIN_W     = 3;
  localparam int MAX_WIDTH = 64;

  // Coverage bin is the top three bits of operand A, for any WIDTH >= 3.
  function automatic logic [BIN_W-1:0] bin_of(input logic [MAX_WIDTH-1:0] a,
                                              input int                   width);
    logic [MAX_WIDTH-1:0] shifted;
    shifted = a >> (width - BIN_W);
    return shifted[BIN_W-1:0];
  endfunction

  function automatic logic [3:0] popcount8(input logic [NUM_BINS-1:0] bits);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      n = n + 4'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/xor_chk_delay_line.sv
// Latency-matched delay line holding {valid, golden[, bin]} entries; bin field
// exists only when XOR_CHK_COVERAGE_EN is defined. Entry pushed at edge N pops at N+LATENCY.
module xor_chk_delay_line
  import xor_chk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_golden,
`ifdef XOR_CHK_COVERAGE_EN
  input  logic [BIN_W-1:0] push_bin,
  output logic [BIN_W-1:0] pop_bin,
`endif
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_golden
);

`ifdef XOR_CHK_COVERAGE_EN
  localparam int ENTRY_W = 1 + WIDTH + BIN_W;
`else
  localparam int ENTRY_W = 1 + WIDTH;
`endif
  localparam int LINE_W = ENTRY_W * LATENCY;

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] pop_entry;
  logic [LINE_W-1:0]  line_q;

`ifdef XOR_CHK_COVERAGE_EN
  assign push_entry = push_valid ? {1'b1, push_golden, push_bin} : '0;
`else
  assign push_entry = push_valid ? {1'b1, push_golden} : '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the line is also reset, since a stale valid bit surviving
  // an abort would produce a spurious compare in the next run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q <= '0;
    end else if (clear) begin
      line_q <= '0;
    end else begin
      line_q <= (line_q << ENTRY_W) | LINE_W'(push_entry);
    end
  end

  assign pop_entry  = line_q[LINE_W-1 -: ENTRY_W];
  assign pop_valid  = pop_entry[ENTRY_W-1];
  assign pop_golden = pop_entry[ENTRY_W-2 -: WIDTH];
`ifdef XOR_CHK_COVERAGE_EN
  assign pop_bin    = pop_entry[BIN_W-1:0];
`endif

endmodule

// File: rtl/xor_result_checker.sv
// Scoreboard for a registered XOR datapath: recomputes a^b, compares y after LATENCY
// cycles, counts results. Operand coverage is built only with XOR_CHK_COVERAGE_EN.
module xor_result_checker
  import xor_chk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_tests,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    y,
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic [CNT_W-1:0]    test_count,
  output logic [CNT_W-1:0]    pass_count,
  output logic [CNT_W-1:0]    fail_count,
  output logic [NUM_BINS-1:0] cov_bins,
  output logic [3:0]          cov_hits
);

  chk_state_e       state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] accepted_q;

  logic             accept_start;
  logic             push;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_golden;
  logic             pop_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept_start = start && (state_q == IDLE || state_q == DONE);
  assign push         = (state_q == RUN) && in_valid && (accepted_q < target_q);
  assign pop_hit      = (y == pop_golden);

`ifdef XOR_CHK_COVERAGE_EN
  logic [BIN_W-1:0]    push_bin;
  logic [BIN_W-1:0]    pop_bin;
  logic [NUM_BINS-1:0] cov_q;

  assign push_bin = bin_of(MAX_WIDTH'(a), WIDTH);
`endif

  xor_chk_delay_line #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept_start),
    .push_valid  (push),
    .push_golden (a ^ b),
`ifdef XOR_CHK_COVERAGE_EN
    .push_bin    (push_bin),
    .pop_bin     (pop_bin),
`endif
    .pop_valid   (pop_valid),
    .pop_golden  (pop_golden)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      accepted_q <= '0;
      test_count <= '0;
      pass_count <= '0;
      fail_count <= '0;
      mismatch   <= 1'b0;
    end else begin
      mismatch <= 1'b0;

      if (pop_valid) begin
        test_count <= sat_inc(test_count);
        if (pop_hit) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          mismatch   <= 1'b1;
        end
      end

      // Start clears the counters after the compare above, so a new run begins at zero.
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            target_q   <= num_tests;
            accepted_q <= '0;
            test_count <= '0;
            pass_count <= '0;
            fail_count <= '0;
          end
        end
        RUN: begin
          if (push) begin
            accepted_q <= accepted_q + 1'b1;
          end
          if (accepted_q == target_q) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (test_count == target_q) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

`ifdef XOR_CHK_COVERAGE_EN
  // Only passing compares mark a bin; a failing result says nothing about coverage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cov_q <= '0;
    end else if (accept_start) begin
      cov_q <= '0;
    end else if (pop_valid && pop_hit) begin
      cov_q[pop_bin] <= 1'b1;
    end
  end

  assign cov_bins = cov_q;
  assign cov_hits = popcount8(cov_q);
`else
  assign cov_bins = '0;
  assign cov_hits = '0;
`endif

endmodule

// File: tb/tb_xor_result_checker.sv
// Self-checking bench: two checkers (LATENCY 1 and 3) watch a modelled XOR block;
// expected counts come from a run-level model of accepted operands and injected errors.
module tb_xor_result_checker;

  localparam int W  = 4;
  localparam int CW = 16;
`ifdef XOR_CHK_COVERAGE_EN
  localparam bit COV_EN = 1'b1;
`else
  localparam bit COV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_tests = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  y1 = '0;
  logic [W-1:0]  y3 = '0;

  logic          busy1, done1, mm1, busy3, done3, mm3;
  logic [CW-1:0] tc1, pc1, fc1, tc3, pc3, fc3;
  logic [7:0]    cb1, cb3;
  logic [3:0]    ch1, ch3;

  int checks = 0;
  int errors = 0;

  // Model state: XOR block output history and the expected result of the current run.
  logic [W-1:0] hist[$];
  int           exp_n, exp_acc, exp_pass, exp_fail;
  logic [7:0]   exp_cov;
  int           mm_seen1, mm_seen3;

  always #5 clk = ~clk;

  xor_result_checker #(.WIDTH(W), .LATENCY(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .num_tests(num_tests),
    .in_valid(in_valid), .a(a), .b(b), .y(y1),
    .busy(busy1), .done(done1), .mismatch(mm1),
    .test_count(tc1), .pass_count(pc1), .fail_count(fc1),
    .cov_bins(cb1), .cov_hits(ch1)
  );

  xor_result_checker #(.WIDTH(W), .LATENCY(3), .CNT_W(CW)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .num_tests(num_tests),
    .in_valid(in_valid), .a(a), .b(b), .y(y3),
    .busy(busy3), .done(done3), .mismatch(mm3),
    .test_count(tc3), .pass_count(pc3), .fail_count(fc3),
    .cov_bins(cb3), .cov_hits(ch3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample pulses, drive operands, advance the XOR block model.
  // flip != 0 corrupts the XOR result for these operands.
  task automatic step(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic [W-1:0] flip);
    @(negedge clk);
    if (mm1) mm_seen1++;
    if (mm3) mm_seen3++;
    start    = 1'b0;
    in_valid = v;
    a        = aa;
    b        = bb;
    hist.push_front((aa ^ bb) ^ flip);
    void'(hist.pop_back());
    y1 = hist[1];
    y3 = hist[3];
    if (v && exp_acc < exp_n) begin
      exp_acc++;
      if (flip == '0) begin
        exp_pass++;
        exp_cov[aa[W-1 -: 3]] = 1'b1;
      end else begin
        exp_fail++;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0);
  endtask

  task automatic pulse_start(input int n, input bit accepted);
    idle();
    start     = 1'b1;
    num_tests = CW'(n);
    if (accepted) begin
      exp_n    = n;
      exp_acc  = 0;
      exp_pass = 0;
      exp_fail = 0;
      exp_cov  = '0;
      mm_seen1 = 0;
      mm_seen3 = 0;
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !(done1 && done3); i++) idle();
    check({tag, "/done1"}, 32'(done1), 32'd1);
    check({tag, "/done3"}, 32'(done3), 32'd1);
    check({tag, "/busy1"}, 32'(busy1), 32'd0);
    check({tag, "/busy3"}, 32'(busy3), 32'd0);
  endtask

  task automatic check_dut(input string tag, input logic [CW-1:0] tc, input logic [CW-1:0] pc,
                           input logic [CW-1:0] fc, input int mm_seen,
                           input logic [7:0] cb, input logic [3:0] ch);
    logic [7:0] want_cov;
    want_cov = COV_EN ? exp_cov : 8'h00;
    check({tag, "/test_count"}, 32'(tc), 32'(exp_acc));
    check({tag, "/pass_count"}, 32'(pc), 32'(exp_pass));
    check({tag, "/fail_count"}, 32'(fc), 32'(exp_fail));
    check({tag, "/mismatch_pulses"}, 32'(mm_seen), 32'(exp_fail));
    check({tag, "/cov_bins"}, 32'(cb), 32'(want_cov));
    check({tag, "/cov_hits"}, 32'(ch), 32'($countones(want_cov)));
  endtask

  task automatic check_run(input string tag);
    wait_done(tag);
    check_dut({tag, "/lat1"}, tc1, pc1, fc1, mm_seen1, cb1, ch1);
    check_dut({tag, "/lat3"}, tc3, pc3, fc3, mm_seen3, cb3, ch3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "/busy1"}, 32'(busy1), 32'd0);
    check({tag, "/done1"}, 32'(done1), 32'd0);
    check({tag, "/mm1"}, 32'(mm1), 32'd0);
    check({tag, "/busy3"}, 32'(busy3), 32'd0);
    check({tag, "/done3"}, 32'(done3), 32'd0);
    check({tag, "/mm3"}, 32'(mm3), 32'd0);
    check_dut({tag, "/lat1"}, tc1, pc1, fc1, 0, cb1, ch1);
    check_dut({tag, "/lat3"}, tc3, pc3, fc3, 0, cb3, ch3);
  endtask

  initial begin
    logic [W-1:0] ta [4];
    logic [W-1:0] tb4 [4];
    ta  = '{4'd0, 4'd3, 4'd9, 4'd15};
    tb4 = '{4'd1, 4'd5, 4'd6, 4'd15};
    for (int i = 0; i < 8; i++) hist.push_back('0);
    exp_n = 0; exp_acc = 0; exp_pass = 0; exp_fail = 0; exp_cov = '0;
    mm_seen1 = 0; mm_seen3 = 0;

    // Power-on reset state.
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Directed run, all results correct.
    pulse_start(4, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, ta[i], tb4[i], '0);
    check_run("t1");

    // Same run, second result forced to 0 (golden 6).
    pulse_start(4, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, ta[i], tb4[i], (i == 1) ? 4'h6 : 4'h0);
    check_run("t2");
    check("t2/one_mismatch", 32'(mm_seen1), 32'd1);

    // Asynchronous reset after 2 of 8 accepted, then a clean run.
    pulse_start(8, 1'b1);
    step(1'b1, 4'd2, 4'd7, '0);
    step(1'b1, 4'd5, 4'd1, '0);
    @(negedge clk);
    reset = 1'b1;
    exp_n = 0; exp_acc = 0; exp_pass = 0; exp_fail = 0; exp_cov = '0;
    #1;
    check_zero("t3_abort");
    idle();
    reset = 1'b0;
    mm_seen1 = 0; mm_seen3 = 0;
    idle();
    check_zero("t3_idle");
    pulse_start(5, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, W'($urandom), W'($urandom), '0);
    check_run("t3_rerun");

    // Zero-length run: done two cycles after start.
    pulse_start(0, 1'b1);
    idle();
    check("t4/busy_e0", 32'(busy1), 32'd1);
    check("t4/done_e0", 32'(done1), 32'd0);
    idle();
    check("t4/done_e1", 32'(done1), 32'd0);
    idle();
    check("t4/done_e2_lat1", 32'(done1), 32'd1);
    check("t4/done_e2_lat3", 32'(done3), 32'd1);
    check_dut("t4/lat1", tc1, pc1, fc1, mm_seen1, cb1, ch1);

    // Start while busy is ignored; num_tests stays at 4.
    pulse_start(4, 1'b1);
    pulse_start(9, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), W'($urandom), '0);
    check_run("t4_busy_start");

    // Coverage: failing compare with a=14 must not set bin 7.
    pulse_start(15, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, W'(i), W'($urandom), '0);
    step(1'b1, 4'd14, W'($urandom), 4'h9);
    check_run("t5_partial");
    pulse_start(16, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, W'(i), W'($urandom), '0);
    check_run("t5_full");

    // Back-to-back run of 10 plus 2 extra valids after the count is reached.
    pulse_start(10, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, W'($urandom), W'($urandom), '0);
    check_run("t6");

    // Randomized runs with gaps and injected errors.
    for (int r = 0; r < 6; r++) begin
      pulse_start(int'($urandom_range(1, 20)), 1'b1);
      for (int c = 0; c < 400 && exp_acc < exp_n; c++) begin
        step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
             ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : '0);
      end
      check_run($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
